// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - recovers pixel position, lock and timing errors from VGA syncs
//
// Purpose: receive-side monitor for a VGA sync stream. Rebuilds pixel_x/pixel_y from
// the hsync/vsync leading edges, measures line and frame periods, reports lock once
// LOCK_CNT consecutive good periods are seen on each axis, and pulses sync_err on a bad
// period or a missing hsync.
// Ports:
//   clk, reset (async, active-low), p_tick (pixel enable), hsync, vsync (sync inputs)
//   pixel_x, pixel_y   recovered position
//   video_on           locked and inside the visible area
//   locked             both axes locked
//   frame_start        one-clk pulse when position (0,0) is entered while locked
//   sync_err           one-clk pulse on a bad period or hsync timeout
module vga_sync_decoder #(
    parameter int H_DISP   = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_DISP   = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int LOCK_CNT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int GW      = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_LOAD     = 10'(H_DISP + H_FP);
    localparam logic [9:0]    V_LOAD     = 10'(V_DISP + V_FP);
    localparam logic [9:0]    H_VIS      = 10'(H_DISP);
    localparam logic [9:0]    V_VIS      = 10'(V_DISP);
    localparam logic [10:0]   H_PER_GOOD = 11'(H_TOTAL - 1);
    localparam logic [10:0]   H_TMO_M1   = 11'(2 * H_TOTAL - 1);
    localparam logic [10:0]   H_PER_MAX  = 11'h7ff;
    localparam logic [9:0]    V_LINES_OK = 10'(V_TOTAL);
    localparam logic [9:0]    V_LINES_MAX = 10'h3ff;
    localparam logic [GW-1:0] LOCK_G     = GW'(LOCK_CNT);

    logic          hs_q, hs_d, vs_q, vs_d;
    logic          vld_q, vld_d;          // previous sample is meaningful
    logic          h_seen_q, h_seen_d;    // first hsync edge already used for measurement
    logic          v_seen_q, v_seen_d;
    logic          tmo_q, tmo_d;          // timeout already reported since last hsync edge
    logic [10:0]   h_per_q, h_per_d;
    logic [9:0]    v_lines_q, v_lines_d;
    logic [GW-1:0] h_good_q, h_good_d, v_good_q, v_good_d;
    logic [9:0]    px_q, px_d, py_q, py_d;
    logic          fs_q, fs_d, se_q, se_d;

    logic h_edge, v_edge, h_bad, v_bad, tmo;

    always_comb begin
        hs_d      = hs_q;
        vs_d      = vs_q;
        vld_d     = vld_q;
        h_seen_d  = h_seen_q;
        v_seen_d  = v_seen_q;
        tmo_d     = tmo_q;
        h_per_d   = h_per_q;
        v_lines_d = v_lines_q;
        h_good_d  = h_good_q;
        v_good_d  = v_good_q;
        px_d      = px_q;
        py_d      = py_q;
        fs_d      = 1'b0;
        se_d      = 1'b0;
        h_edge    = 1'b0;
        v_edge    = 1'b0;
        h_bad     = 1'b0;
        v_bad     = 1'b0;
        tmo       = 1'b0;

        if (p_tick) begin
            hs_d   = hsync;
            vs_d   = vsync;
            vld_d  = 1'b1;
            h_edge = vld_q && (hsync == SYNC_POL) && (hs_q != SYNC_POL);
            v_edge = vld_q && (vsync == SYNC_POL) && (vs_q != SYNC_POL);

            // Position: the sync edges land at fixed coordinates, so reload there.
            if (h_edge)
                px_d = H_LOAD;
            else if (px_q == H_LAST)
                px_d = 10'd0;
            else
                px_d = px_q + 10'd1;

            if (v_edge)
                py_d = V_LOAD;
            else if (!h_edge && px_q == H_LAST)
                py_d = (py_q == V_LAST) ? 10'd0 : py_q + 10'd1;

            // Line period
            if (h_edge) begin
                h_per_d  = 11'd0;
                h_seen_d = 1'b1;
                tmo_d    = 1'b0;
                if (h_seen_q) begin
                    if (h_per_q == H_PER_GOOD)
                        h_good_d = (h_good_q == LOCK_G) ? h_good_q : h_good_q + 1'b1;
                    else
                        h_bad = 1'b1;
                end
            end else begin
                if (h_per_q != H_PER_MAX)
                    h_per_d = h_per_q + 11'd1;
                if (h_per_q == H_TMO_M1 && !tmo_q) begin
                    tmo   = 1'b1;
                    tmo_d = 1'b1;
                end
            end

            // Frame period, measured in hsync edges
            if (h_edge && v_lines_q != V_LINES_MAX)
                v_lines_d = v_lines_q + 10'd1;
            if (v_edge) begin
                // a coincident hsync edge belongs to the new frame
                v_lines_d = h_edge ? 10'd1 : 10'd0;
                v_seen_d  = 1'b1;
                if (v_seen_q) begin
                    if (v_lines_q == V_LINES_OK)
                        v_good_d = (v_good_q == LOCK_G) ? v_good_q : v_good_q + 1'b1;
                    else
                        v_bad = 1'b1;
                end
            end

            // Any failure drops lock on both axes
            if (h_bad || v_bad || tmo) begin
                h_good_d = '0;
                v_good_d = '0;
            end

            se_d = h_bad || v_bad || tmo;
            fs_d = (px_d == 10'd0) && (py_d == 10'd0) &&
                   (h_good_d == LOCK_G) && (v_good_d == LOCK_G);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            vld_q     <= 1'b0;
            h_seen_q  <= 1'b0;
            v_seen_q  <= 1'b0;
            tmo_q     <= 1'b0;
            h_per_q   <= '0;
            v_lines_q <= '0;
            h_good_q  <= '0;
            v_good_q  <= '0;
            px_q      <= '0;
            py_q      <= '0;
            fs_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            vld_q     <= vld_d;
            h_seen_q  <= h_seen_d;
            v_seen_q  <= v_seen_d;
            tmo_q     <= tmo_d;
            h_per_q   <= h_per_d;
            v_lines_q <= v_lines_d;
            h_good_q  <= h_good_d;
            v_good_q  <= v_good_d;
            px_q      <= px_d;
            py_q      <= py_d;
            fs_q      <= fs_d;
            se_q      <= se_d;
        end
    end

    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign locked      = (h_good_q == LOCK_G) && (v_good_q == LOCK_G);
    assign video_on    = locked && (px_q < H_VIS) && (py_q < V_VIS);
    assign frame_start = fs_q;
    assign sync_err    = se_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed bench for vga_sync_decoder, both sync polarities
module tb_vga_sync_decoder;

    localparam int HD = 8, HF = 2, HSW = 3, HB = 3, HT = HD + HF + HSW + HB;  // 16
    localparam int VD = 6, VF = 1, VSW = 2, VB = 2, VT = VD + VF + VSW + VB;  // 11
    localparam int FT = HT * VT;                                              // 176 ticks

    logic clk, reset, p_tick;
    logic hsync0, vsync0, hsync1, vsync1;
    logic [9:0] px0, py0, px1, py1;
    logic vo0, lk0, fs0, se0, vo1, lk1, fs1, se1;
    logic [23:0] dout [2];
    logic [23:0] samp [2];

    int n_cmp = 0, n_fail = 0;
    int gen_hc, gen_vc, gen_vlen, bad_line;
    bit hold, cmp_on, found;
    int se_cnt [2];
    int fs_cnt [2];

    typedef struct {
        int         t;
        logic [9:0] px;
        logic [9:0] py;
        logic       vo, lk, fs, se;
    } vec_t;
    vec_t vec [13];

    vga_sync_decoder #(.H_DISP(HD), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                       .V_DISP(VD), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                       .SYNC_POL(1'b0), .LOCK_CNT(2)) dut0 (
        .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync0), .vsync(vsync0),
        .pixel_x(px0), .pixel_y(py0), .video_on(vo0), .locked(lk0),
        .frame_start(fs0), .sync_err(se0));

    vga_sync_decoder #(.H_DISP(HD), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
                       .V_DISP(VD), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
                       .SYNC_POL(1'b1), .LOCK_CNT(2)) dut1 (
        .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync1), .vsync(vsync1),
        .pixel_x(px1), .pixel_y(py1), .video_on(vo1), .locked(lk1),
        .frame_start(fs1), .sync_err(se1));

    assign dout[0] = {px0, py0, vo0, lk0, fs0, se0};
    assign dout[1] = {px1, py1, vo1, lk1, fs1, se1};

    always #5 clk = ~clk;

    function automatic vec_t mk(int t, int px, int py, bit vo, bit lk, bit fs, bit se);
        vec_t v;
        v.t = t; v.px = 10'(px); v.py = 10'(py);
        v.vo = vo; v.lk = lk; v.fs = fs; v.se = se;
        return v;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
        end
    endtask

    // One pixel tick from the reference generator followed by an idle clk.
    task automatic gtick();
        logic ha, va;
        logic [23:0] e;
        int lim;
        ha = !hold && gen_hc >= HD + HF && gen_hc < HD + HF + HSW;
        va = !hold && gen_vc >= VD + VF && gen_vc < VD + VF + VSW;
        hsync0 = ~ha; vsync0 = ~va;
        hsync1 = ha;  vsync1 = va;
        p_tick = 1'b1;
        @(posedge clk); #1;
        p_tick = 1'b0;
        for (int k = 0; k < 2; k++) begin
            samp[k] = dout[k];
            se_cnt[k] += int'(dout[k][0]);
            fs_cnt[k] += int'(dout[k][1]);
        end
        if (cmp_on && !hold) begin
            e = {10'(gen_hc), 10'(gen_vc), (gen_hc < HD && gen_vc < VD), 1'b1,
                 (gen_hc == 0 && gen_vc == 0), 1'b0};
            for (int k = 0; k < 2; k++) chk("track", k, {8'h0, samp[k]}, {8'h0, e});
        end
        if (!hold) begin
            lim = (gen_vc == bad_line) ? HT - 1 : HT;
            if (gen_hc == lim - 1) begin
                gen_hc = 0;
                gen_vc = (gen_vc == gen_vlen - 1) ? 0 : gen_vc + 1;
            end else begin
                gen_hc++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic sync_frame();
        for (int t = 0; t < 2 * FT && !(gen_hc == 0 && gen_vc == 0); t++) gtick();
    endtask

    task automatic clr_cnt();
        for (int k = 0; k < 2; k++) begin se_cnt[k] = 0; fs_cnt[k] = 0; end
    endtask

    initial begin
        int ci;
        clk = 1'b0; reset = 1'b0; p_tick = 1'b0;
        hsync0 = 1'b1; vsync0 = 1'b1; hsync1 = 1'b0; vsync1 = 1'b0;
        gen_hc = 0; gen_vc = 0; gen_vlen = VT; bad_line = -1;
        hold = 1'b0; cmp_on = 1'b0;
        clr_cnt();

        vec[0]  = mk(0,   1,  0, 0, 0, 0, 0);
        vec[1]  = mk(5,   6,  0, 0, 0, 0, 0);
        vec[2]  = mk(10,  10, 0, 0, 0, 0, 0);
        vec[3]  = mk(42,  10, 2, 0, 0, 0, 0);
        vec[4]  = mk(112, 0,  7, 0, 0, 0, 0);
        vec[5]  = mk(463, 15, 6, 0, 0, 0, 0);
        vec[6]  = mk(464, 0,  7, 0, 1, 0, 0);
        vec[7]  = mk(528, 0,  0, 1, 1, 1, 0);
        vec[8]  = mk(529, 1,  0, 1, 1, 0, 0);
        vec[9]  = mk(535, 7,  0, 1, 1, 0, 0);
        vec[10] = mk(536, 8,  0, 0, 1, 0, 0);
        vec[11] = mk(615, 7,  5, 1, 1, 0, 0);
        vec[12] = mk(624, 0,  6, 0, 1, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) chk("reset_state", k, {8'h0, dout[k]}, 32'h0);
        reset = 1'b1;

        // Clean reference run: lock at the third vsync edge, then track every tick.
        ci = 0;
        for (int t = 0; t < 5 * FT; t++) begin
            cmp_on = (t >= 464);
            gtick();
            if (ci < 13 && vec[ci].t == t) begin
                for (int k = 0; k < 2; k++)
                    chk($sformatf("vec_t%0d", t), k, {8'h0, samp[k]},
                        {8'h0, vec[ci].px, vec[ci].py, vec[ci].vo, vec[ci].lk,
                         vec[ci].fs, vec[ci].se});
                ci++;
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk("frame_start_count", k, fs_cnt[k], 2);
            chk("clean_sync_err_count", k, se_cnt[k], 0);
        end

        // Line 2 shortened by one tick: error at the following hsync edge.
        clr_cnt();
        bad_line = 2;
        for (int t = 0; t < 300; t++) begin
            cmp_on = (t >= 288);
            if (t == 60) bad_line = -1;
            gtick();
            for (int k = 0; k < 2; k++) begin
                if (t == 56) chk("short_line_pre_lk", k, samp[k][2], 1);
                if (t == 57) begin
                    chk("short_line_err", k, samp[k][0], 1);
                    chk("short_line_lk", k, samp[k][2], 0);
                    chk("short_line_px", k, samp[k][23:14], 10);
                end
                if (t == 286) chk("short_line_relock_pre", k, samp[k][2], 0);
                if (t == 287) chk("short_line_relock", k, samp[k][2], 1);
            end
        end
        for (int k = 0; k < 2; k++) chk("short_line_err_count", k, se_cnt[k], 1);

        // Hsync held deasserted: one timeout pulse only.
        sync_frame();
        for (int t = 0; t < FT; t++) gtick();
        cmp_on = 1'b0;
        clr_cnt();
        hold = 1'b1;
        for (int s = 0; s < 60; s++) begin
            gtick();
            for (int k = 0; k < 2; k++) begin
                if (s == 25) begin
                    chk("stuck_pre_lk", k, samp[k][2], 1);
                    chk("stuck_pre_err", k, samp[k][0], 0);
                end
                if (s == 26) begin
                    chk("stuck_tmo_err", k, samp[k][0], 1);
                    chk("stuck_tmo_lk", k, samp[k][2], 0);
                    chk("stuck_tmo_vo", k, samp[k][3], 0);
                end
            end
        end
        for (int k = 0; k < 2; k++) chk("stuck_err_count", k, se_cnt[k], 1);
        hold = 1'b0; gen_hc = 0; gen_vc = 0;
        found = 1'b0;
        for (int t = 0; t < 4 * FT && !found; t++) begin
            gtick();
            if (samp[0][2] && samp[1][2]) found = 1'b1;
        end
        chk("stuck_relock", 0, 32'(found), 1);
        cmp_on = 1'b1;
        sync_frame();
        for (int t = 0; t < FT; t++) gtick();

        // One frame of VT-1 lines: error at the next vsync edge.
        cmp_on = 1'b0;
        clr_cnt();
        gen_vlen = VT - 1;
        for (int t = 0; t < 300; t++) begin
            if (t == 170) gen_vlen = VT;
            gtick();
            for (int k = 0; k < 2; k++) begin
                if (t == 271) begin
                    chk("short_frame_pre_lk", k, samp[k][2], 1);
                    chk("short_frame_pre_err", k, samp[k][0], 0);
                end
                if (t == 272) begin
                    chk("short_frame_err", k, samp[k][0], 1);
                    chk("short_frame_lk", k, samp[k][2], 0);
                    chk("short_frame_py", k, samp[k][13:4], 7);
                end
            end
        end
        for (int k = 0; k < 2; k++) chk("short_frame_err_count", k, se_cnt[k], 1);

        // Asynchronous reset mid-line, then clean reacquisition.
        found = 1'b0;
        for (int t = 0; t < 4 * FT && !found; t++) begin
            gtick();
            if (samp[0][2] && samp[1][2]) found = 1'b1;
        end
        chk("pre_reset_lock", 0, 32'(found), 1);
        for (int t = 0; t < 2 * HT && gen_hc != 6; t++) gtick();
        for (int k = 0; k < 2; k++) chk("pre_reset_px", k, dout[k][23:14], 5);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) chk("async_reset", k, {8'h0, dout[k]}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        clr_cnt();
        for (int t = 0; t < 3 * FT; t++) gtick();
        for (int k = 0; k < 2; k++) begin
            chk("post_reset_err_count", k, se_cnt[k], 0);
            chk("post_reset_lock", k, samp[k][2], 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA sync generator: consumes hsync/vsync plus the pixel tick and reconstructs pixel_x, pixel_y and video_on.
- Checks line and frame periods, asserts lock once timing is stable, and flags timing errors.
- Used as an in-fabric monitor/loopback checker for the pong, text and bitmap video paths.

Parameters:
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels after display, before hsync)
- H_SYNC, 96, hsync width in pixels
- H_BP, 48, horizontal back porch
- V_DISP, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- LOCK_CNT, 2, consecutive good periods required for lock (per axis)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- p_tick  in  1  pixel enable (one clk per pixel)
- hsync  in  1  horizontal sync from generator
- vsync  in  1  vertical sync from generator
- pixel_x  out  10  recovered column, 0..H_TOTAL-1
- pixel_y  out  10  recovered row, 0..V_TOTAL-1
- video_on  out  1  locked and inside the visible area
- locked  out  1  h_locked AND v_locked
- frame_start  out  1  one-clk pulse at pixel (0,0)
- sync_err  out  1  one-clk pulse on any bad period or timeout

Behaviour:
- H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP (525).
- All state advances only on clk edges with p_tick=1. The one exception: reset asynchronously forces every register to 0, and the outputs then read pixel_x=0, pixel_y=0, video_on=0, locked=0, frame_start=0, sync_err=0.
- Reset mid-frame discards lock; reacquisition requires full LOCK_CNT again.
- Sync inputs are sampled into hs_q/vs_q on each tick.
- An edge is detected when the sample equals SYNC_POL and the previous sample did not. Edge detection is valid from the second tick after reset.
- pixel_x:
  - On an hsync edge tick, load H_DISP+H_FP (656).
  - Otherwise, wrap 799 to 0; else increment.
- pixel_y:
  - On a vsync edge tick, load V_DISP+V_FP (490). This takes priority over the increment.
  - Otherwise, on the tick where pixel_x wraps 799 to 0, wrap 524 to 0; else increment.
- Horizontal period check:
  - Counter h_per (11 bits, saturating at 2047) counts ticks since the last hsync edge.
  - At each hsync edge: good if h_per+1 == H_TOTAL. Then h_per restarts at 0.
  - Good: h_good increments, saturating at LOCK_CNT.
  - Bad: h_good and v_good clear, h_locked and v_locked clear, sync_err pulses.
  - h_locked = (h_good == LOCK_CNT).
- Vertical period check:
  - Counter v_lines (10 bits, saturating at 1023) counts hsync edges since the last vsync edge.
  - At each vsync edge: good if v_lines == V_TOTAL, otherwise bad (same clear/err rule as horizontal).
  - v_lines then restarts at 0, or at 1 if an hsync edge falls on the same tick.
  - The first edge after reset is measurement-only: it is neither good nor bad and raises no sync_err.
- Timeout:
  - h_per reaching 2*H_TOTAL (1600) with no hsync edge drops all lock and pulses sync_err once.
  - Further timeouts do not re-pulse until an edge is seen.
- Outputs:
  - video_on = locked & pixel_x<H_DISP & pixel_y<V_DISP (combinational from registers).
  - frame_start pulses for one clk, registered, on the tick where the new pixel_x=0 and pixel_y=0, and only if locked.
- Latency: pixel_x/pixel_y are valid one clk after the tick that sampled the sync level.
- Stuck sync (continuously asserted or deasserted) produces no edges, so timeout is the only exit.

Test Plan:
- Reference 640x480 generator, SYNC_POL=0, p_tick every 2nd clk, 3 frames.
  - locked rises at the second vsync edge after the first clean measurement.
  - pixel_x/pixel_y match the generator counters on every tick from lock onward.
  - frame_start pulses exactly once per 420000 ticks.
- Corrupt one line to 799 ticks after lock.
  - sync_err pulses once at that hsync edge; locked drops.
  - locked re-asserts after LOCK_CNT good lines plus good frames.
- Hold hsync deasserted after lock.
  - At h_per=1600: sync_err pulse, locked=0, video_on=0.
  - No further sync_err until hsync resumes.
- Frame with 524 lines.
  - sync_err at the vsync edge; v_locked clears.
  - pixel_y reloads to 490 at that edge.
- Assert reset (low) mid-line at pixel_x=300.
  - All outputs are 0 immediately, without waiting for a clk edge.
  - After release, no sync_err on the first edges; lock reacquired within 3 frames.
- SYNC_POL=1 with inverted generator syncs.
  - Behaviour identical to the first scenario.
